// File: rtl/time_counter.sv
// Packed-BCD HH:MM:SS timekeeping register for the alarm clock.
// Counts seconds from a prescaler, or takes per-digit adjust pulses while frozen.
module time_counter #(
    parameter logic [31:0] TICK_CYCLES = 32'd100000000
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Enable_Count,
    input  logic        i_Seconds_1st_Digit_Inc,
    input  logic        i_Seconds_1st_Digit_Dec,
    input  logic        i_Seconds_2nd_Digit_Inc,
    input  logic        i_Seconds_2nd_Digit_Dec,
    input  logic        i_Minutes_1st_Digit_Inc,
    input  logic        i_Minutes_1st_Digit_Dec,
    input  logic        i_Minutes_2nd_Digit_Inc,
    input  logic        i_Minutes_2nd_Digit_Dec,
    input  logic        i_Hours_1st_Digit_Inc,
    input  logic        i_Hours_1st_Digit_Dec,
    input  logic        i_Hours_2nd_Digit_Inc,
    input  logic        i_Hours_2nd_Digit_Dec,
    output logic [31:0] o_Time,
    output logic        o_Second_Tick
);

    localparam logic [31:0] TERMINAL = TICK_CYCLES - 32'd1;

    logic [31:0] r_Prescale;
    logic        w_Tick;

    logic [3:0] r_Sec_Ones, r_Sec_Tens;
    logic [3:0] r_Min_Ones, r_Min_Tens;
    logic [3:0] r_Hr_Ones,  r_Hr_Tens;

    logic [3:0] w_Sec_Ones, w_Sec_Tens;
    logic [3:0] w_Min_Ones, w_Min_Tens;
    logic [3:0] w_Hr_Ones,  w_Hr_Tens;

    logic [3:0] w_Hr_Ones_Limit;
    logic [3:0] w_Hr_Tens_Adj;

    function automatic logic [3:0] dig_inc(
        input logic [3:0] d,
        input logic [3:0] lim
    );
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] dig_dec(
        input logic [3:0] d,
        input logic [3:0] lim
    );
        return (d == 4'd0) ? lim : d - 4'd1;
    endfunction

    // Terminal count only counts as a tick while enabled, so a falling
    // enable on the terminal cycle drops the tick.
    assign w_Tick = i_Enable_Count && (r_Prescale == TERMINAL);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Prescale <= 32'd0;
        end else if (!i_Enable_Count || w_Tick) begin
            r_Prescale <= 32'd0;
        end else begin
            r_Prescale <= r_Prescale + 32'd1;
        end
    end

    assign w_Hr_Ones_Limit = (r_Hr_Tens == 4'd2) ? 4'd3 : 4'd9;

    always_comb begin
        w_Hr_Tens_Adj = r_Hr_Tens;
        if (i_Hours_2nd_Digit_Inc) begin
            w_Hr_Tens_Adj = dig_inc(r_Hr_Tens, 4'd2);
        end else begin
            w_Hr_Tens_Adj = dig_dec(r_Hr_Tens, 4'd2);
        end
    end

    always_comb begin
        w_Sec_Ones = r_Sec_Ones;
        w_Sec_Tens = r_Sec_Tens;
        w_Min_Ones = r_Min_Ones;
        w_Min_Tens = r_Min_Tens;
        w_Hr_Ones  = r_Hr_Ones;
        w_Hr_Tens  = r_Hr_Tens;

        if (w_Tick) begin
            if (r_Sec_Ones != 4'd9) begin
                w_Sec_Ones = r_Sec_Ones + 4'd1;
            end else begin
                w_Sec_Ones = 4'd0;
                if (r_Sec_Tens != 4'd5) begin
                    w_Sec_Tens = r_Sec_Tens + 4'd1;
                end else begin
                    w_Sec_Tens = 4'd0;
                    if (r_Min_Ones != 4'd9) begin
                        w_Min_Ones = r_Min_Ones + 4'd1;
                    end else begin
                        w_Min_Ones = 4'd0;
                        if (r_Min_Tens != 4'd5) begin
                            w_Min_Tens = r_Min_Tens + 4'd1;
                        end else begin
                            w_Min_Tens = 4'd0;
                            if (r_Hr_Tens == 4'd2 && r_Hr_Ones == 4'd3) begin
                                w_Hr_Tens = 4'd0;
                                w_Hr_Ones = 4'd0;
                            end else if (r_Hr_Ones == 4'd9) begin
                                w_Hr_Ones = 4'd0;
                                w_Hr_Tens = r_Hr_Tens + 4'd1;
                            end else begin
                                w_Hr_Ones = r_Hr_Ones + 4'd1;
                            end
                        end
                    end
                end
            end
        end else if (!i_Enable_Count) begin
            priority case (1'b1)
                i_Seconds_1st_Digit_Inc:
                    w_Sec_Ones = dig_inc(r_Sec_Ones, 4'd9);
                i_Seconds_1st_Digit_Dec:
                    w_Sec_Ones = dig_dec(r_Sec_Ones, 4'd9);
                i_Seconds_2nd_Digit_Inc:
                    w_Sec_Tens = dig_inc(r_Sec_Tens, 4'd5);
                i_Seconds_2nd_Digit_Dec:
                    w_Sec_Tens = dig_dec(r_Sec_Tens, 4'd5);
                i_Minutes_1st_Digit_Inc:
                    w_Min_Ones = dig_inc(r_Min_Ones, 4'd9);
                i_Minutes_1st_Digit_Dec:
                    w_Min_Ones = dig_dec(r_Min_Ones, 4'd9);
                i_Minutes_2nd_Digit_Inc:
                    w_Min_Tens = dig_inc(r_Min_Tens, 4'd5);
                i_Minutes_2nd_Digit_Dec:
                    w_Min_Tens = dig_dec(r_Min_Tens, 4'd5);
                i_Hours_1st_Digit_Inc:
                    w_Hr_Ones = dig_inc(r_Hr_Ones, w_Hr_Ones_Limit);
                i_Hours_1st_Digit_Dec:
                    w_Hr_Ones = dig_dec(r_Hr_Ones, w_Hr_Ones_Limit);
                i_Hours_2nd_Digit_Inc,
                i_Hours_2nd_Digit_Dec: begin
                    // Landing on tens=2 clamps ones so 24..29 never appear
                    w_Hr_Tens = w_Hr_Tens_Adj;
                    if (w_Hr_Tens_Adj == 4'd2 && r_Hr_Ones > 4'd3) begin
                        w_Hr_Ones = 4'd3;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Sec_Ones    <= 4'd0;
            r_Sec_Tens    <= 4'd0;
            r_Min_Ones    <= 4'd0;
            r_Min_Tens    <= 4'd0;
            r_Hr_Ones     <= 4'd0;
            r_Hr_Tens     <= 4'd0;
            o_Second_Tick <= 1'b0;
        end else begin
            r_Sec_Ones    <= w_Sec_Ones;
            r_Sec_Tens    <= w_Sec_Tens;
            r_Min_Ones    <= w_Min_Ones;
            r_Min_Tens    <= w_Min_Tens;
            r_Hr_Ones     <= w_Hr_Ones;
            r_Hr_Tens     <= w_Hr_Tens;
            o_Second_Tick <= w_Tick;
        end
    end

    assign o_Time = {8'h00,
                     r_Hr_Tens, r_Hr_Ones,
                     r_Min_Tens, r_Min_Ones,
                     r_Sec_Tens, r_Sec_Ones};

endmodule

// File: tb/tb_time_counter.sv
// Directed-vector bench for time_counter with a 4-cycle second.
// Inputs change 1 time unit after each rising edge; outputs sampled there too.
module tb_time_counter;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b0;
    logic        i_Enable_Count = 1'b0;
    logic [11:0] adj = 12'h000;
    logic [31:0] o_Time;
    logic        o_Second_Tick;

    int n_vec = 0;
    int n_err = 0;
    int n_ticks;

    localparam logic [11:0] S1_INC = 12'h001;
    localparam logic [11:0] S1_DEC = 12'h002;
    localparam logic [11:0] S2_INC = 12'h004;
    localparam logic [11:0] M1_DEC = 12'h020;
    localparam logic [11:0] M1_INC = 12'h010;
    localparam logic [11:0] M2_INC = 12'h040;
    localparam logic [11:0] M2_DEC = 12'h080;
    localparam logic [11:0] H1_INC = 12'h100;
    localparam logic [11:0] H1_DEC = 12'h200;
    localparam logic [11:0] H2_INC = 12'h400;
    localparam logic [11:0] H2_DEC = 12'h800;

    time_counter #(.TICK_CYCLES(32'd4)) dut (
        .i_Clk                   (i_Clk),
        .i_Reset                 (i_Reset),
        .i_Enable_Count          (i_Enable_Count),
        .i_Seconds_1st_Digit_Inc (adj[0]),
        .i_Seconds_1st_Digit_Dec (adj[1]),
        .i_Seconds_2nd_Digit_Inc (adj[2]),
        .i_Seconds_2nd_Digit_Dec (adj[3]),
        .i_Minutes_1st_Digit_Inc (adj[4]),
        .i_Minutes_1st_Digit_Dec (adj[5]),
        .i_Minutes_2nd_Digit_Inc (adj[6]),
        .i_Minutes_2nd_Digit_Dec (adj[7]),
        .i_Hours_1st_Digit_Inc   (adj[8]),
        .i_Hours_1st_Digit_Dec   (adj[9]),
        .i_Hours_2nd_Digit_Inc   (adj[10]),
        .i_Hours_2nd_Digit_Dec   (adj[11]),
        .o_Time                  (o_Time),
        .o_Second_Tick           (o_Second_Tick)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        i_Enable_Count = 1'b0;
        adj = 12'h000;
        i_Reset = 1'b1;
        step();
        i_Reset = 1'b0;
    endtask

    task automatic pulse(input logic [11:0] v);
        adj = v;
        step();
        adj = 12'h000;
    endtask

    task automatic pulses(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) pulse(v);
    endtask

    // Builds a time from 00:00:00 using increment pulses only
    task automatic set_time(input int ht, input int ho, input int mt,
                            input int mo, input int st, input int so);
        pulses(H2_INC, ht);
        pulses(H1_INC, ho);
        pulses(M2_INC, mt);
        pulses(M1_INC, mo);
        pulses(S2_INC, st);
        pulses(S1_INC, so);
    endtask

    initial begin
        // reset state
        i_Reset = 1'b1;
        #12;
        check("reset_time", o_Time, 32'h0);
        check("reset_tick", {31'h0, o_Second_Tick}, 32'h0);

        // count from reset
        @(posedge i_Clk);
        #1;
        i_Reset = 1'b0;
        i_Enable_Count = 1'b1;
        steps(3);
        check("pre_first_tick", o_Time, 32'h0);
        step();
        check("first_tick_time", o_Time, 32'h1);
        check("first_tick_pulse", {31'h0, o_Second_Tick}, 32'h1);
        n_ticks = 1;
        for (int i = 0; i < 36; i++) begin
            step();
            if (o_Second_Tick) n_ticks++;
        end
        check("forty_cycles_time", o_Time, 32'h10);
        check("forty_cycles_ticks", n_ticks, 32'd10);

        // enable drops on the terminal cycle: tick lost, prescaler cleared
        do_reset();
        i_Enable_Count = 1'b1;
        steps(3);
        i_Enable_Count = 1'b0;
        step();
        check("drop_tick_time", o_Time, 32'h0);
        check("drop_tick_pulse", {31'h0, o_Second_Tick}, 32'h0);
        i_Enable_Count = 1'b1;
        steps(3);
        check("drop_restart_early", o_Time, 32'h0);
        step();
        check("drop_restart_tick", o_Time, 32'h1);

        // midnight rollover
        do_reset();
        set_time(2, 3, 5, 9, 5, 9);
        check("set_235959", o_Time, 32'h00235959);
        i_Enable_Count = 1'b1;
        steps(3);
        check("roll_hold", o_Time, 32'h00235959);
        step();
        check("roll_time", o_Time, 32'h0);
        check("roll_tick", {31'h0, o_Second_Tick}, 32'h1);

        // hours clamp
        do_reset();
        set_time(1, 9, 0, 0, 0, 0);
        check("set_19", o_Time, 32'h00190000);
        pulse(H2_INC);
        check("h2_inc_clamp", o_Time, 32'h00230000);
        pulse(H1_INC);
        check("h1_inc_wrap3", o_Time, 32'h00200000);
        pulse(H1_DEC);
        check("h1_dec_to3", o_Time, 32'h00230000);
        pulse(H2_INC);
        check("h2_inc_wrap", o_Time, 32'h00030000);
        pulse(H2_DEC);
        check("h2_dec_wrap", o_Time, 32'h00230000);

        // digit wraps without carry
        do_reset();
        set_time(0, 0, 0, 0, 5, 9);
        pulse(S1_INC);
        check("s1_inc_wrap", o_Time, 32'h00000050);
        do_reset();
        pulse(M2_DEC);
        check("m2_dec_wrap", o_Time, 32'h00005000);
        pulse(S1_DEC);
        check("s1_dec_wrap", o_Time, 32'h00005009);
        pulse(M1_DEC);
        check("m1_dec_wrap", o_Time, 32'h00005909);

        // priority
        do_reset();
        pulse(S1_INC | H1_INC);
        check("prio_s1_over_h1", o_Time, 32'h1);
        pulse(S1_DEC | S2_INC);
        check("prio_dec_over_s2", o_Time, 32'h0);
        pulse(S1_INC | S1_DEC);
        check("prio_inc_over_dec", o_Time, 32'h1);

        // pulses ignored while counting
        do_reset();
        i_Enable_Count = 1'b1;
        adj = H1_INC | M1_INC;
        steps(3);
        check("gate_no_change", o_Time, 32'h0);
        step();
        adj = 12'h000;
        check("gate_tick_only", o_Time, 32'h1);

        // async reset between edges
        do_reset();
        set_time(1, 2, 3, 4, 5, 6);
        check("set_123456", o_Time, 32'h00123456);
        i_Enable_Count = 1'b1;
        steps(2);
        #2;
        i_Reset = 1'b1;
        #1;
        check("async_reset_now", o_Time, 32'h0);
        step();
        i_Reset = 1'b0;
        steps(3);
        check("post_reset_early", o_Time, 32'h0);
        step();
        check("post_reset_tick", o_Time, 32'h1);
        check("post_reset_pulse", {31'h0, o_Second_Tick}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
